// File: rtl/ecall_uart_pkg.sv
// Shared types and constants for the ecall-to-UART sink.
package ecall_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BITS_PER_BYTE;
    localparam int unsigned BIT_W          = $clog2(BITS_PER_BYTE);
    localparam int unsigned BYTE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/ecall_fifo.sv
// Synchronous FIFO; a push into a full FIFO is still taken when a pop frees the slot on the same edge.
module ecall_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c,
    output logic              full_c,
    output logic              empty_c,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        pop_ok   = pop && !empty_c;
        push_ok  = push && (!full_c || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/ecall_uart_tx.sv
// Captures CPU ecall words into a FIFO and shifts them out as four 8N1 UART bytes, LSB byte first.
module ecall_uart_tx
    import ecall_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ecall_ready,
    input  logic [31:0]       i_ecall_data,
    input  logic              i_clear,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_fifo_count,
    output logic              o_overflow,
    output logic [31:0]       o_last_data
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic [WORD_W-1:0]   last_data_q, last_data_d;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;

    logic                baud_wrap;
    logic [BIT_W-1:0]    nxt_bit;
    logic [BITS_PER_BYTE-1:0] cur_byte;
    logic                accept;

    ecall_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (i_ecall_ready),
        .pop     (fifo_pop),
        .wdata   (i_ecall_data),
        .rdata_c (fifo_rdata),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

    // Line FSM: the next line level is registered, so tx changes only on a baud wrap or the pop.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        baud_wrap   = (baud_q == BAUD_W'(CLK_DIV - 1));
        nxt_bit     = bit_idx_q + BIT_W'(1);
        cur_byte    = word_q[{byte_idx_q, 3'b000} +: BITS_PER_BYTE];

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    word_d     = fifo_rdata;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = cur_byte[0];
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_W'(BITS_PER_BYTE - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = nxt_bit;
                        tx_d      = cur_byte[nxt_bit];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (byte_idx_q != BYTE_W'(BYTES_PER_WORD - 1)) begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        bit_idx_d  = '0;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // A drop on the same edge as a clear leaves the flag set.
        accept      = i_ecall_ready && (!fifo_full || fifo_pop);
        overflow_d  = overflow_q;
        if (i_clear) begin
            overflow_d = 1'b0;
        end
        if (i_ecall_ready && !accept) begin
            overflow_d = 1'b1;
        end
        last_data_d = accept ? i_ecall_data : last_data_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            last_data_q <= last_data_d;
        end
    end

    assign o_uart_tx    = tx_q;
    assign o_busy       = busy_q;
    assign o_fifo_count = fifo_count;
    assign o_overflow   = overflow_q;
    assign o_last_data  = last_data_q;

endmodule

// File: tb/tb_ecall_uart_tx.sv
// Bench for ecall_uart_tx: timeline model of the line plus a UART decoder and directed corner sequences.
module tb_ecall_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int FRAME = 40 * DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] data  = 32'h0;
    logic        tx;
    logic        busy;
    logic        ovf;
    logic [CW-1:0] cnt;
    logic [31:0] last;

    always #5 clk = ~clk;

    ecall_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ecall_ready (ready),
        .i_ecall_data  (data),
        .i_clear       (clear),
        .o_uart_tx     (tx),
        .o_busy        (busy),
        .o_fifo_count  (cnt),
        .o_overflow    (ovf),
        .o_last_data   (last)
    );

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int peak  = 0;

    always @(negedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: a popped word owns the line for FRAME cycles, then one idle cycle before the next pop.
    logic [31:0] m_q[$];
    logic        m_ovf;
    logic [31:0] m_last;
    logic [31:0] m_word;
    int          m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_last = 32'h0;
            m_word = 32'h0;
            m_pop  = -1000000;
        end else begin : step
            int sz;
            bit pop;
            bit acc;
            sz  = m_q.size();
            pop = (sz > 0) && (cyc >= m_pop + FRAME + 1);
            acc = ready && ((sz < DEPTH) || pop);
            if (pop) begin
                m_word = m_q.pop_front();
                m_pop  = cyc;
            end
            if (acc) begin
                m_q.push_back(data);
                m_last = data;
            end
            if (clear) m_ovf = 1'b0;
            if (ready && !acc) m_ovf = 1'b1;
        end
    end

    function automatic logic exp_tx(input int o, input logic [31:0] w);
        int f;
        int b;
        if (o < 0 || o >= FRAME) return 1'b1;
        f = o / (10 * DIV);
        b = (o % (10 * DIV)) / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return w[8 * f + b - 1];
    endfunction

    initial begin : scoreboard
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin : cmp
                int o;
                o = cyc - m_pop;
                chk("line_tx", tx, exp_tx(o, m_word));
                chk("busy", busy, (o >= 0 && o < FRAME));
                chk("fifo_count", cnt, m_q.size());
                chk("overflow", ovf, m_ovf);
                chk("last_data", last, m_last);
                if (int'(cnt) > peak) peak = int'(cnt);
            end
        end
    end

    // UART receiver: samples mid-bit, discards any frame interrupted by reset.
    logic [7:0] rx_q[$];
    int         st_q[$];

    initial begin : rx_mon
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && tx === 1'b0) begin : frame
                int st;
                bit ok;
                logic [9:0] fr;
                st = cyc;
                ok = 1'b1;
                fr = '0;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? DIV / 2 : DIV) begin
                        @(posedge clk);
                        #2;
                        if (!rst_n) ok = 1'b0;
                    end
                    fr[k] = tx;
                end
                if (ok) begin
                    chk("rx_start_bit", fr[0], 1'b0);
                    chk("rx_stop_bit", fr[9], 1'b1);
                    rx_q.push_back(fr[8:1]);
                    st_q.push_back(st);
                end
            end
        end
    end

    logic [7:0] exp_b[$];

    task automatic push_exp_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_b.push_back(w[8 * k +: 8]);
    endtask

    task automatic chk_rx(input string name);
        chk({name, "_nbytes"}, rx_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_b[i]);
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        ready = 1'b1;
        data  = d;
        @(negedge clk);
        ready = 1'b0;
        data  = $urandom;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while ((busy !== 1'b0 || cnt !== '0) && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, "_in_time"}, (k < max), 1'b1);
        repeat (4) @(negedge clk);
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] bytes;
        int          busy_cycles;
    } vec_t;

    vec_t vec[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int nb;
        logic [31:0] w;

        vec[0] = '{32'h12345678, 32'h78563412, 160};
        vec[1] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 160};
        vec[2] = '{32'h0000FFFF, 32'hFFFF0000, 160};
        vec[3] = '{32'h00000001, 32'h01000000, 160};
        vec[4] = '{32'hDEADBEEF, 32'hEFBEADDE, 160};
        vec[5] = '{32'h80000001, 32'h01000080, 160};

        #23;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", cnt, 0);
        chk("rst_overflow", ovf, 1'b0);
        chk("rst_last", last, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single words from the table: latency, busy length, byte order.
        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            st_q.delete();
            exp_b.delete();
            @(negedge clk);
            ready = 1'b1;
            data  = vec[v].data;
            @(posedge clk);
            #1;
            chk("t_count_after_push", cnt, 1);
            chk("t_tx_at_push", tx, 1'b1);
            @(negedge clk);
            ready = 1'b0;
            data  = ~vec[v].data;
            @(posedge clk);
            #1;
            chk("t_start_next_cycle", tx, 1'b0);
            nb = 0;
            while (busy === 1'b1 && nb < 1000) begin
                nb++;
                @(posedge clk);
                #1;
            end
            chk("t_busy_cycles", nb, vec[v].busy_cycles);
            chk("t_last_data", last, vec[v].data);
            repeat (4) @(negedge clk);
            for (int k = 0; k < 4; k++) exp_b.push_back(vec[v].bytes[31 - 8 * k -: 8]);
            chk_rx("t_rx");
        end

        // Overflow: six back-to-back words, word 5 dropped.
        rx_q.delete();
        exp_b.delete();
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ready = 1'b1;
            data  = 32'(i);
        end
        @(negedge clk);
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_peak", peak, 4);
        wait_idle("ovf_drain", 2000);
        for (int i = 0; i < 5; i++) push_exp_word(32'(i));
        chk_rx("ovf_rx");

        // Clear on the same edge as a drop: set wins; clear alone then clears.
        rx_q.delete();
        exp_b.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ready = 1'b1;
            data  = 32'h100 + 32'(i);
        end
        @(negedge clk);
        ready = 1'b1;
        clear = 1'b1;
        data  = 32'h1FF;
        @(posedge clk);
        #1;
        chk("clr_full", cnt, 4);
        chk("clr_set_wins", ovf, 1'b1);
        @(negedge clk);
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_alone", ovf, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        wait_idle("clr_drain", 2000);
        for (int i = 0; i < 5; i++) push_exp_word(32'h100 + 32'(i));
        chk_rx("clr_rx");

        // Back-to-back words: one idle cycle between words, none between bytes.
        rx_q.delete();
        st_q.delete();
        exp_b.delete();
        push_word(32'hA5A5A5A5);
        push_word(32'h0000FFFF);
        wait_idle("b2b_drain", 1000);
        chk("b2b_frames", st_q.size(), 8);
        for (int j = 1; j < 8 && j < st_q.size(); j++)
            chk($sformatf("b2b_gap%0d", j), st_q[j] - st_q[j - 1], (j == 4) ? 10 * DIV + 1 : 10 * DIV);
        exp_b = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00};
        chk_rx("b2b_rx");

        // Reset during DATA bit 3 of byte 1 with two words queued.
        @(negedge clk);
        ready = 1'b1;
        data  = 32'h11223344;
        @(negedge clk);
        data  = 32'h55667788;
        @(negedge clk);
        data  = 32'h99AABBCC;
        @(negedge clk);
        ready = 1'b0;
        repeat (57) @(posedge clk);
        #3;
        chk("mid_busy", busy, 1'b1);
        chk("mid_count", cnt, 2);
        chk("mid_tx_bit3", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_count", cnt, 0);
        chk("mid_rst_last", last, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        rx_q.delete();
        exp_b.delete();
        push_word(32'h00000001);
        wait_idle("post_rst_drain", 1000);
        exp_b = '{8'h01, 8'h00, 8'h00, 8'h00};
        chk_rx("post_rst_rx");

        // Pointer wrap: ten spaced words through a depth-4 FIFO.
        rx_q.delete();
        exp_b.delete();
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            push_word(w);
            push_exp_word(w);
            repeat (45 * DIV - 2) @(negedge clk);
        end
        wait_idle("wrap_drain", 1000);
        chk_rx("wrap_rx");
        chk("wrap_no_overflow", ovf, 1'b0);

        // Random traffic against the timeline model.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 99) < 10);
            clear = ($urandom_range(0, 199) == 0);
            data  = $urandom;
        end
        @(negedge clk);
        ready = 1'b0;
        clear = 1'b0;
        wait_idle("rand_drain", 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
